// File: rtl/kronos_hpm_bank.sv
// kronos_hpm_bank: a bank of hardware performance counters for the Kronos CSR unit.
// Counter 0 counts every cycle. Counters 1..NCOUNTERS-1 count the event chosen by
// their event-select register. The low half uses a 32-bit adder. A carry out of the
// low half reaches the high half one cycle later. High-half reads forward that
// pending carry, so software never sees a torn value. Each counter has an inhibit
// input, a sticky overflow flag and a shared overflow interrupt.
module kronos_hpm_bank #(
    parameter int NCOUNTERS = 4,
    parameter int WIDTH     = 64,
    parameter int NEVENTS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NEVENTS-1:0]   events,
    input  logic                 rd_en,
    input  logic [4:0]           rd_sel,
    input  logic                 rd_hi,
    output logic [31:0]          rd_data,
    output logic                 rd_vld,
    input  logic                 wr_en,
    input  logic [4:0]           wr_sel,
    input  logic                 wr_hi,
    input  logic [31:0]          wr_data,
    input  logic                 evsel_we,
    input  logic [NCOUNTERS-1:0] inhibit,
    input  logic [NCOUNTERS-1:0] ovf_clr,
    output logic [NCOUNTERS-1:0] ovf,
    output logic                 ovf_irq
);

    localparam int ESW = $clog2(NEVENTS + 1);
    localparam int HW  = WIDTH - 32;

    logic [31:0]          lo      [NCOUNTERS];
    logic [HW-1:0]        hi      [NCOUNTERS];
    logic [HW-1:0]        hi_fwd  [NCOUNTERS];
    logic [ESW-1:0]       evsel   [NCOUNTERS];
    logic [NCOUNTERS-1:0] carry;
    logic [NCOUNTERS-1:0] inc;
    logic [NCOUNTERS-1:0] lo_wr;
    logic [NCOUNTERS-1:0] hi_wr;
    logic [NCOUNTERS-1:0] ev_wr;
    logic [NCOUNTERS-1:0] ovf_set;
    logic [NEVENTS:0]     ev_ext;
    logic [31:0]          rd_next;

    // Event select value k picks events[k-1]. Bit 0 is tied low, so select 0 never counts.
    assign ev_ext = {events, 1'b0};

    // Per-counter decode: increment enable, write strobes, overflow set and forwarded high half
    always_comb begin
        // NOTE: every output of this block gets a default before any condition, so no latches are inferred.
        inc     = '0;
        lo_wr   = '0;
        hi_wr   = '0;
        ev_wr   = '0;
        ovf_set = '0;
        for (int i = 0; i < NCOUNTERS; i++) begin
            if (i == 0) begin
                inc[i] = ~inhibit[i];
            end else begin
                inc[i] = ~inhibit[i] & ev_ext[evsel[i]] & (int'(evsel[i]) <= NEVENTS);
            end
            lo_wr[i]   = wr_en & ~wr_hi & (wr_sel == 5'(i));
            hi_wr[i]   = wr_en &  wr_hi & (wr_sel == 5'(i));
            ev_wr[i]   = evsel_we & (wr_sel == 5'(i)) & (i != 0);
            // A carry that lands on an all-ones high half wraps it and flags overflow,
            // unless a high write in the same cycle discards that carry.
            ovf_set[i] = carry[i] & ~hi_wr[i] & (&hi[i]);
            // Compute at the high-half width so that the forwarded value wraps like the counter.
            hi_fwd[i]  = hi[i] + HW'(carry[i]);
        end
    end

    // Read mux: an out-of-range index matches no counter and returns zero
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NCOUNTERS; i++) begin
            if (rd_sel == 5'(i)) begin
                rd_next = rd_hi ? 32'(hi_fwd[i]) : lo[i];
            end
        end
    end

    // Counter halves, staggered carry, event selects and sticky overflow flags
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are a few flops per counter, not RAM, so resetting them costs nothing special.
            for (int i = 0; i < NCOUNTERS; i++) begin
                lo[i]    <= '0;
                hi[i]    <= '0;
                evsel[i] <= '0;
            end
            carry   <= '0;
            ovf     <= '0;
            ovf_irq <= 1'b0;
        end else begin
            // NOTE: all state updates here are non-blocking, so every read in this block sees pre-edge values.
            for (int i = 0; i < NCOUNTERS; i++) begin
                if (lo_wr[i]) begin
                    lo[i] <= wr_data;
                end else if (inc[i]) begin
                    lo[i] <= lo[i] + 32'd1;
                end
                // A low write beats the increment, so a wrap is only possible without one.
                carry[i] <= inc[i] & ~lo_wr[i] & (&lo[i]);

                if (hi_wr[i]) begin
                    hi[i] <= wr_data[HW-1:0];
                end else if (carry[i]) begin
                    hi[i] <= hi[i] + HW'(1);
                end

                if (ev_wr[i]) begin
                    evsel[i] <= wr_data[ESW-1:0];
                end

                if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end else if (ovf_set[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
            ovf_irq <= |ovf;
        end
    end

    // Registered read port: data is sampled in the request cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_kronos_hpm_bank.sv
// Testbench for kronos_hpm_bank. The reference model keeps each counter as a single
// WIDTH-bit value. Each read request pushes its expected data into a queue. A monitor
// pops the queue and compares whenever rd_vld is seen.
`timescale 1ns/1ps
module tb_kronos_hpm_bank;

    localparam int NC     = 4;
    localparam int W      = 40;
    localparam int NE     = 8;
    localparam int ESW_TB = $clog2(NE + 1);
    localparam int HWB    = W - 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] events;
    logic          rd_en;
    logic [4:0]    rd_sel;
    logic          rd_hi;
    logic [31:0]   rd_data;
    logic          rd_vld;
    logic          wr_en;
    logic [4:0]    wr_sel;
    logic          wr_hi;
    logic [31:0]   wr_data;
    logic          evsel_we;
    logic [NC-1:0] inhibit;
    logic [NC-1:0] ovf_clr;
    logic [NC-1:0] ovf;
    logic          ovf_irq;

    kronos_hpm_bank #(.NCOUNTERS(NC), .WIDTH(W), .NEVENTS(NE)) dut (
        .clk      (clk),
        .rst      (rst),
        .events   (events),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_hi    (rd_hi),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_hi    (wr_hi),
        .wr_data  (wr_data),
        .evsel_we (evsel_we),
        .inhibit  (inhibit),
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
        .ovf_irq  (ovf_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          sel;
        bit          hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: one full-width value per counter, plus an overflow due to
    // land one cycle after the wrapping increment
    logic [W-1:0]  m_cnt   [NC];
    int            m_evsel [NC];
    logic [NC-1:0] m_ovf;
    logic [NC-1:0] m_pend;
    logic          m_irq;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t          e;
        logic [W-1:0]  v;
        logic [NC-1:0] ovf_old;
        bit            inc;
        bit            lw;
        bit            hw;
        bit            land;
        int            idx;
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i]   = '0;
                m_evsel[i] = 0;
            end
            m_ovf  = '0;
            m_pend = '0;
            m_irq  = 1'b0;
            return;
        end
        if (rd_en) begin
            idx   = int'(rd_sel);
            e.sel = idx;
            e.hi  = rd_hi;
            if (idx < NC) e.val = rd_hi ? 32'(m_cnt[idx] >> 32) : m_cnt[idx][31:0];
            else          e.val = 32'h0;
            exp_q.push_back(e);
        end
        ovf_old = m_ovf;
        for (int i = 0; i < NC; i++) begin
            inc  = !inhibit[i] &&
                   (i == 0 || (m_evsel[i] >= 1 && m_evsel[i] <= NE && events[m_evsel[i] - 1]));
            lw   = wr_en && !wr_hi && int'(wr_sel) == i;
            hw   = wr_en &&  wr_hi && int'(wr_sel) == i;
            land = m_pend[i] && !hw;
            m_pend[i] = 1'b0;
            v = m_cnt[i];
            if (hw) v[W-1:32] = wr_data[HWB-1:0];
            if (lw) begin
                v[31:0] = wr_data;
            end else if (inc) begin
                m_pend[i] = (v == '1);
                v = v + 1;
            end
            m_cnt[i] = v;
            if (ovf_clr[i])  m_ovf[i] = 1'b0;
            else if (land)   m_ovf[i] = 1'b1;
            if (evsel_we && i != 0 && int'(wr_sel) == i)
                m_evsel[i] = int'(wr_data) & ((1 << ESW_TB) - 1);
        end
        m_irq = |ovf_old;
    endtask

    // One clock: update the model with the current inputs, clock the DUT, check the flags, clear pulses
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("ovf_irq", 32'(ovf_irq), 32'(m_irq));
        events   = '0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        evsel_we = 1'b0;
        ovf_clr  = '0;
    endtask

    task automatic do_read(int sel, bit hi);
        rd_en = 1'b1; rd_sel = 5'(sel); rd_hi = hi;
        cycle();
    endtask

    task automatic do_write(int sel, bit hi, logic [31:0] d);
        wr_en = 1'b1; wr_sel = 5'(sel); wr_hi = hi; wr_data = d;
        cycle();
    endtask

    task automatic do_evsel(int sel, logic [31:0] d);
        evsel_we = 1'b1; wr_sel = 5'(sel); wr_data = d;
        cycle();
    endtask

    // Load a counter so that its next increment wraps the full value
    task automatic load_top(int sel, logic [31:0] hi_val);
        do_write(sel, 1'b1, hi_val);
        do_write(sel, 1'b0, 32'hFFFF_FFFF);
    endtask

    // Monitor: compare each read response against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_vld: got unexpected pulse, expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd ctr%0d %s", e.sel, e.hi ? "hi" : "lo"), rd_data, e.val);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; events = '0; rd_en = 1'b0; rd_sel = '0; rd_hi = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_hi = 1'b0; wr_data = '0; evsel_we = 1'b0;
        inhibit = '0; ovf_clr = '0;

        // Reset for two cycles, then read back every half
        cycle();
        cycle();
        rst = 1'b0;
        check("rd_vld after reset", 32'(rd_vld), 32'h0);
        for (int i = 0; i < NC; i++) begin
            do_read(i, 1'b0);
            do_read(i, 1'b1);
        end

        // Staggered carry on mcycle with a forwarded high read
        do_write(0, 1'b0, 32'hFFFF_FFFF);
        do_write(0, 1'b1, 32'h1234_5678);
        do_read(0, 1'b1);
        cycle();
        do_read(0, 1'b1);
        do_read(0, 1'b0);

        // Event select: counter 2 follows events[2]; counter 3 (select 0) never counts
        do_evsel(2, 32'd3);
        for (int k = 0; k < 10; k++) begin
            events[2] = 1'b1;
            if (k < 5) events[0] = 1'b1;
            cycle();
        end
        do_read(2, 1'b0);
        do_read(3, 1'b0);
        do_read(2, 1'b1);

        // Inhibit freezes mcycle, and releasing it resumes counting
        inhibit[0] = 1'b1;
        do_read(0, 1'b0);
        repeat (18) cycle();
        do_read(0, 1'b0);
        inhibit[0] = 1'b0;
        do_read(0, 1'b0);
        do_read(0, 1'b0);
        do_read(0, 1'b0);

        // Overflow of counter 1: sticky flag, interrupt one cycle later, then clear
        do_evsel(1, 32'd1);
        load_top(1, 32'h0000_00FF);
        events[0] = 1'b1;
        cycle();
        do_read(1, 1'b1);
        do_read(1, 1'b0);
        cycle();
        ovf_clr[1] = 1'b1;
        cycle();
        cycle();

        // A clear in the landing cycle beats the overflow set
        load_top(1, 32'h0000_00FF);
        events[0] = 1'b1;
        cycle();
        ovf_clr[1] = 1'b1;
        cycle();
        cycle();

        // A high write in the landing cycle drops the carry and the overflow
        load_top(1, 32'h0000_00FF);
        events[0] = 1'b1;
        cycle();
        do_write(1, 1'b1, 32'h0000_0012);
        do_read(1, 1'b1);
        cycle();

        // A low write in the landing cycle still lets the carry reach the high half
        load_top(1, 32'h0000_0010);
        events[0] = 1'b1;
        cycle();
        do_write(1, 1'b0, 32'h0000_0007);
        do_read(1, 1'b1);
        do_read(1, 1'b0);

        // Collision: a write beats an event, and a read in the same cycle returns the old value
        events[0] = 1'b1;
        wr_en = 1'b1; wr_sel = 5'd1; wr_hi = 1'b0; wr_data = 32'd5;
        rd_en = 1'b1; rd_sel = 5'd1; rd_hi = 1'b0;
        cycle();
        do_read(1, 1'b0);

        // Out-of-range indices, ignored event-select writes and selects above NEVENTS
        do_read(7, 1'b0);
        do_read(31, 1'b1);
        do_write(5, 1'b0, 32'h0000_0123);
        do_evsel(0, 32'd1);
        do_evsel(9, 32'd1);
        do_evsel(3, 32'd9);
        for (int k = 0; k < 5; k++) begin
            events = '1;
            cycle();
        end
        do_read(3, 1'b0);
        do_read(0, 1'b1);

        // Reset mid-operation with a carry pending and a read request in the reset cycle
        do_write(0, 1'b0, 32'hFFFF_FFFF);
        rst = 1'b1;
        rd_en = 1'b1; rd_sel = 5'd0; rd_hi = 1'b1;
        cycle();
        rst = 1'b0;
        do_read(0, 1'b1);
        do_read(0, 1'b0);
        do_read(1, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 599) == 0);
            events = NE'($urandom);
            if ($urandom_range(0, 19) == 0) inhibit = NC'($urandom);
            rd_en  = ($urandom_range(0, 2) != 0);
            rd_sel = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(0, NC - 1));
            rd_hi  = 1'($urandom);
            wr_en  = ($urandom_range(0, 7) == 0);
            wr_sel = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, NC - 1));
            wr_hi  = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       wr_data = $urandom;
                1:       wr_data = 32'hFFFF_FFFF;
                2:       wr_data = 32'hFFFF_FFFE;
                default: wr_data = 32'h0000_00FF;
            endcase
            evsel_we = ($urandom_range(0, 29) == 0);
            ovf_clr  = ($urandom_range(0, 15) == 0) ? NC'($urandom) : '0;
            cycle();
        end
        rst = 1'b0;
        inhibit = '0;
        for (int i = 0; i < NC; i++) begin
            do_read(i, 1'b0);
            do_read(i, 1'b1);
        end

        // Drain: every request must have produced exactly one response
        cycle();
        cycle();
        check("pending_reads", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
